// File: rtl/mc_cmd_pkg.sv
// Shared definitions for the memory-controller command encoder and decoder:
// opcodes, encoder FSM states and the 32-bit command word.
package mc_cmd_pkg;

    localparam int unsigned ADDR_W = 28;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned CMD_W  = OP_W + ADDR_W;
    localparam int unsigned CNT_W  = $clog2(16);

    typedef enum logic [OP_W-1:0] {
        OP_NOP = 4'h0,
        OP_ACT = 4'h1,
        OP_RD  = 4'h2,
        OP_WR  = 4'h3,
        OP_PRE = 4'h4
    } mc_opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_WAIT_RP,
        ST_ACT,
        ST_WAIT_RCD,
        ST_RW
    } mc_state_e;

    typedef struct packed {
        mc_opcode_e          opcode;
        logic [ADDR_W-1:0]   addr;
    } mc_cmd_t;

endpackage

// File: rtl/mc_timing_counter.sv
// Loadable down-counter used for the tRP / tRCD waits; saturates at zero.
module mc_timing_counter
    import mc_cmd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero_c
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_c = (count_q == '0);

endmodule

// File: rtl/mc_command_encoder.sv
// Turns READ/WRITE requests into ACTIVATE/PRECHARGE/READ/WRITE commands,
// tracking one open row and enforcing tRP / tRCD spacing.
module mc_command_encoder
    import mc_cmd_pkg::*;
#(
    parameter int unsigned T_RCD   = 3,
    parameter int unsigned T_RP    = 2,
    parameter int unsigned ROW_LSB = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              flush,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [CMD_W-1:0]  cmd_out,
    output logic              row_open,
    output logic              busy
);

    localparam int unsigned ROW_W = ADDR_W - ROW_LSB;

    // A wait state covers T-1 cycles, so the counter is loaded with T-2 and the
    // wait state is skipped entirely when T is 1.
    localparam bit               RP_WAIT  = (T_RP > 1);
    localparam bit               RCD_WAIT = (T_RCD > 1);
    localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'(RP_WAIT ? T_RP - 2 : 0);
    localparam logic [CNT_W-1:0] RCD_LOAD = CNT_W'(RCD_WAIT ? T_RCD - 2 : 0);

    mc_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  hold_addr_q, hold_addr_d;
    logic               hold_write_q, hold_write_d;
    logic               pend_q, pend_d;
    logic [ROW_W-1:0]   open_row_q, open_row_d;
    logic               row_open_q, row_open_d;
    logic               cmd_valid_q, cmd_valid_d;
    mc_cmd_t            cmd_q, cmd_d;
    logic               busy_q, busy_d;

    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_load_val;
    logic               cnt_dec;
    logic               cnt_zero_c;
    logic               accept_c;
    logic               hs_c;
    logic               row_hit_c;

    mc_timing_counter u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero_c   (cnt_zero_c)
    );

    assign req_ready = reset && (state_q == ST_IDLE) && !flush;
    assign accept_c  = req_valid && req_ready;
    assign hs_c      = cmd_valid_q && cmd_ready;
    assign row_hit_c = (req_addr[ADDR_W-1:ROW_LSB] == open_row_q);

    // Next-state and request/row bookkeeping
    always_comb begin
        state_d      = state_q;
        hold_addr_d  = hold_addr_q;
        hold_write_d = hold_write_q;
        pend_d       = pend_q;
        open_row_d   = open_row_q;
        row_open_d   = row_open_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    if (row_open_q) begin
                        state_d = ST_PRE;
                        pend_d  = 1'b0;
                    end
                end else if (accept_c) begin
                    hold_addr_d  = req_addr;
                    hold_write_d = req_write;
                    pend_d       = 1'b1;
                    if (!row_open_q) begin
                        state_d = ST_ACT;
                    end else if (row_hit_c) begin
                        state_d = ST_RW;
                    end else begin
                        state_d = ST_PRE;
                    end
                end
            end
            ST_PRE: begin
                if (hs_c) begin
                    row_open_d = 1'b0;
                    if (RP_WAIT) begin
                        cnt_load     = 1'b1;
                        cnt_load_val = RP_LOAD;
                        state_d      = ST_WAIT_RP;
                    end else begin
                        state_d = pend_q ? ST_ACT : ST_IDLE;
                    end
                end
            end
            ST_WAIT_RP: begin
                if (cnt_zero_c) begin
                    state_d = pend_q ? ST_ACT : ST_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_ACT: begin
                if (hs_c) begin
                    row_open_d = 1'b1;
                    open_row_d = hold_addr_q[ADDR_W-1:ROW_LSB];
                    if (RCD_WAIT) begin
                        cnt_load     = 1'b1;
                        cnt_load_val = RCD_LOAD;
                        state_d      = ST_WAIT_RCD;
                    end else begin
                        state_d = ST_RW;
                    end
                end
            end
            ST_WAIT_RCD: begin
                if (cnt_zero_c) begin
                    state_d = ST_RW;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_RW: begin
                if (hs_c) begin
                    pend_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered command word derived from the next state; stable while stalled
    always_comb begin
        cmd_valid_d = 1'b0;
        cmd_d       = '{opcode: OP_NOP, addr: '0};
        busy_d      = (state_d != ST_IDLE);
        unique case (state_d)
            ST_PRE: begin
                cmd_valid_d = 1'b1;
                cmd_d       = '{opcode: OP_PRE, addr: {open_row_d, {ROW_LSB{1'b0}}}};
            end
            ST_ACT: begin
                cmd_valid_d = 1'b1;
                cmd_d       = '{opcode: OP_ACT, addr: hold_addr_d};
            end
            ST_RW: begin
                cmd_valid_d = 1'b1;
                cmd_d       = '{opcode: (hold_write_d ? OP_WR : OP_RD), addr: hold_addr_d};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            hold_addr_q  <= '0;
            hold_write_q <= 1'b0;
            pend_q       <= 1'b0;
            open_row_q   <= '0;
            row_open_q   <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_q        <= '{opcode: OP_NOP, addr: '0};
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_addr_q  <= hold_addr_d;
            hold_write_q <= hold_write_d;
            pend_q       <= pend_d;
            open_row_q   <= open_row_d;
            row_open_q   <= row_open_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_q        <= cmd_d;
            busy_q       <= busy_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_out   = cmd_q;
    assign row_open  = row_open_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mc_command_encoder.sv
// Scoreboard bench for mc_command_encoder: expected commands and their
// latencies are queued with the stimulus and checked as cmd_valid appears.
module tb_mc_command_encoder;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [27:0] req_addr;
    logic        flush;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_out;
    logic        row_open;
    logic        busy;

    mc_command_encoder #(.T_RCD(3), .T_RP(2), .ROW_LSB(14)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .flush     (flush),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_out   (cmd_out),
        .row_open  (row_open),
        .busy      (busy)
    );

    typedef struct {
        logic [31:0] cmd;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   last_evt = 0;
    bit   valid_seen = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [31:0] cmd, input int lat);
        exp_t e;
        e.cmd = cmd;
        e.lat = lat;
        exp_q.push_back(e);
    endtask

    // Latency is measured from the most recent accept, flush or command handshake
    always @(negedge clk) begin
        if (!reset) begin
            valid_seen = 0;
        end else begin
            if (req_valid && req_ready) last_evt = cyc;
            if (flush) last_evt = cyc;
            if (cmd_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_cmd", 32'(cmd_valid), 32'd0);
                end else begin
                    check_eq("cmd", cmd_out, exp_q[0].cmd);
                    if (!valid_seen) begin
                        valid_seen = 1;
                        if (exp_q[0].lat > 0)
                            check_eq("lat", 32'(cyc - last_evt), 32'(exp_q[0].lat));
                    end
                    if (cmd_ready) begin
                        void'(exp_q.pop_front());
                        valid_seen = 0;
                        last_evt   = cyc;
                    end
                end
            end
        end
    end

    task automatic wait_accept();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk);
                #1 req_valid = 1'b0;
                return;
            end
        end
        check_eq("req_accept_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic do_req(input logic [27:0] addr, input logic wr);
        req_addr  = addr;
        req_write = wr;
        req_valid = 1'b1;
        wait_accept();
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0) return;
        end
        check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        flush     = 1'b0;
        cmd_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check_eq("rst_cmd_out",   cmd_out, 32'h0000_0000);
        check_eq("rst_row_open",  32'(row_open), 32'd0);
        check_eq("rst_busy",      32'(busy), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        reset = 1'b1;
        #1 check_eq("ready_after_rst", 32'(req_ready), 32'd1);

        // Flush with no open row is ignored
        @(posedge clk); #1 flush = 1'b1;
        #1 check_eq("ready_flush_low", 32'(req_ready), 32'd0);
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check_eq("flush_no_row_busy", 32'(busy), 32'd0);

        // Cold read
        @(posedge clk); #1;
        push_exp(32'h1000_4123, 1);
        push_exp(32'h2000_4123, 3);
        do_req(28'h000_4123, 1'b0);
        wait_drain();
        #1 check_eq("row_open_cold", 32'(row_open), 32'd1);

        // Row hit write
        push_exp(32'h3000_4FFF, 1);
        do_req(28'h000_4FFF, 1'b1);
        wait_drain();

        // Row miss read
        #1;
        push_exp(32'h4000_4000, 1);
        push_exp(32'h1000_8000, 2);
        push_exp(32'h2000_8000, 3);
        do_req(28'h000_8000, 1'b0);
        wait_drain();

        // Flush and request together: flush wins, request serviced cold after
        #1;
        push_exp(32'h4000_8000, 1);
        push_exp(32'h1000_C010, 1);
        push_exp(32'h2000_C010, 3);
        req_addr  = 28'h000_C010;
        req_write = 1'b0;
        req_valid = 1'b1;
        flush     = 1'b1;
        #1 check_eq("ready_flush_req", 32'(req_ready), 32'd0);
        @(posedge clk); #1 flush = 1'b0;
        wait_accept();
        wait_drain();

        // Flush alone closes the open row and returns to IDLE
        #1;
        push_exp(32'h4000_C000, 1);
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        wait_drain();
        repeat (2) @(posedge clk);
        #1;
        check_eq("flush_row_closed", 32'(row_open), 32'd0);
        check_eq("flush_idle_busy",  32'(busy), 32'd0);

        // Backpressure on ACTIVATE for five cycles
        cmd_ready = 1'b0;
        push_exp(32'h1001_0020, 1);
        push_exp(32'h3001_0020, 3);
        do_req(28'h001_0020, 1'b1);
        repeat (5) begin
            @(negedge clk);
            check_eq("bp_valid", 32'(cmd_valid), 32'd1);
        end
        @(posedge clk); #1 cmd_ready = 1'b1;
        wait_drain();

        // Reset during WAIT_RCD aborts the access
        #1;
        push_exp(32'h4001_0000, 1);
        push_exp(32'h1002_0000, 2);
        do_req(28'h002_0000, 1'b0);
        wait_drain();
        #1 reset = 1'b0;
        #1;
        check_eq("abort_cmd_valid", 32'(cmd_valid), 32'd0);
        check_eq("abort_row_open",  32'(row_open), 32'd0);
        check_eq("abort_busy",      32'(busy), 32'd0);
        check_eq("abort_cmd_out",   cmd_out, 32'h0000_0000);
        check_eq("abort_req_ready", 32'(req_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1 check_eq("ready_after_abort", 32'(req_ready), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        check_eq("post_abort_busy", 32'(busy), 32'd0);
        check_eq("post_abort_pending", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mc_command_encoder.md
MC_COMMAND_ENCODER -- requirements
Module: mc_command_encoder

Interface
REQ-001 SHALL have parameter T_RCD, default 3: minimum cycles from the ACTIVATE handshake to the READ/WRITE cmd_valid (range 1..15).
REQ-002 SHALL have parameter T_RP, default 2: minimum cycles from the PRECHARGE handshake to the ACTIVATE cmd_valid (range 1..15).
REQ-003 SHALL have parameter ROW_LSB, default 14: row field is req_addr[27:ROW_LSB].
REQ-004 Ports: clk  in  1  single clock; all logic on its rising edge.
REQ-005 Ports: reset  in  1  asynchronous, active-low reset.
REQ-006 Ports: req_valid  in  1  access request present.
REQ-007 Ports: req_ready  out  1  encoder can accept a request.
REQ-008 Ports: req_write  in  1  1 = WRITE access, 0 = READ access.
REQ-009 Ports: req_addr  in  28  access address.
REQ-010 Ports: flush  in  1  single-cycle request to close the open row.
REQ-011 Ports: cmd_valid  out  1  cmd_out holds a command.
REQ-012 Ports: cmd_ready  in  1  downstream decoder accepts cmd_out.
REQ-013 Ports: cmd_out  out  32  {opcode[3:0], addr[27:0]}.
REQ-014 Ports: row_open  out  1  a row is currently activated.
REQ-015 Ports: busy  out  1  FSM not in IDLE.

Function
REQ-016 Opcodes SHALL be NOP 0x0, ACTIVATE 0x1, READ 0x2, WRITE 0x3, PRECHARGE 0x4; cmd_out[27:0] SHALL be the held request address, or the open-row address for PRECHARGE.
REQ-017 FSM states SHALL be IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, RW.
REQ-018 req_ready SHALL be 1 only in IDLE with flush low; a request SHALL be accepted on req_valid & req_ready and latched into a holding register.
REQ-019 On acceptance: row hit (row_open, equal row) -> RW; row miss (row_open, different row) -> PRE; no open row -> ACT.
REQ-020 Row-hit latency: request accepted in cycle N -> cmd_valid with READ/WRITE in cycle N+1.
REQ-021 cmd_valid SHALL be asserted in PRE, ACT and RW only; cmd_out SHALL stay stable while cmd_valid & !cmd_ready.
REQ-022 Transitions SHALL occur only on cmd_valid & cmd_ready: PRE -> WAIT_RP, ACT -> WAIT_RCD, RW -> IDLE.
REQ-023 PRE handshake in cycle P -> ACTIVATE cmd_valid no earlier than, and exactly at, cycle P+T_RP; likewise ACT handshake in cycle M -> RW cmd_valid at M+T_RCD.
REQ-024 The wait counter SHALL be $clog2(16) bits wide, loaded on the handshake and decremented to zero; zero SHALL advance the state.
REQ-025 ACT handshake SHALL set row_open and record the row; PRE handshake SHALL clear row_open.
REQ-026 flush in IDLE with row_open SHALL go to PRE with no request outstanding, then return to IDLE after WAIT_RP; flush with no open row, or outside IDLE, SHALL be ignored.
REQ-027 flush and req_valid in the same IDLE cycle: flush wins; the request is not accepted (req_ready low).
REQ-028 cmd_valid SHALL never carry NOP.

Reset
REQ-029 Reset assertion SHALL immediately force IDLE, cmd_valid 0, cmd_out 0x00000000, row_open 0, busy 0, counter 0 and holding register 0, aborting any in-flight sequence without issuing a further command.
REQ-030 req_ready SHALL be 0 while reset is asserted and 1 in the first cycle after deassertion.

Structure
REQ-031 Opcode constants, the state enum and the command-word typedef SHALL live in package mc_cmd_pkg, which is shared with the command decoder.
REQ-032 The wait timer SHALL be the sub-module mc_timing_counter (load, count-down, zero flag).

Verification
REQ-033 Cold read, with cmd_ready tied high: req addr 0x0004123, read -> ACT 0x10004123, READ 0x20004123 exactly T_RCD=3 cycles after the ACT handshake.
REQ-034 Row hit: after REQ-033, write to 0x0004FFF -> WRITE 0x30004FFF one cycle after acceptance, with no ACT.
REQ-035 Row miss: read 0x0008000 with row 0x0004000 open -> PRE 0x40004000, ACT 0x10008000 2 cycles later, READ 0x20008000 3 cycles after the ACT.
REQ-036 Backpressure: cmd_ready low for 5 cycles during ACT -> cmd_out held at 0x1xxxxxxx and stable; T_RCD timing starts from the eventual handshake.
REQ-037 flush and req_valid together in IDLE with a row open -> PRE issued, request held off (req_ready 0), then the request is serviced cold via ACT.
REQ-038 Reset asserted in WAIT_RCD -> cmd_valid 0 and row_open 0 immediately; no READ/WRITE emitted after release.
